// File: rtl/array_pkg.sv
// Shared types for the array burst master: FSM states, read-FIFO entry,
// and the address-width helper used to size the array address port.
package array_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 2048;

    // Default-width entry; parameterised users declare their own copy.
    typedef struct packed {
        logic                 last;
        logic [DEF_WIDTH-1:0] data;
    } rd_entry_t;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int DEF_AW = addr_w(DEF_DEPTH);

endpackage

// File: rtl/array_rd_fifo.sv
// Two-entry synchronous FIFO holding read words ({last, data}).
// Ports: i_push/i_data write side, i_pop/o_data read side (head),
// o_full/o_empty status. Async active-low reset empties it.
module array_rd_fifo #(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty
);

    logic [DW-1:0] r_mem [2];
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (i_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_cnt <= r_cnt + 2'(i_push) - 2'(i_pop);
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_full  = (r_cnt == 2'd2);
    assign o_empty = (r_cnt == 2'd0);

endmodule

// File: rtl/array_burst_master.sv
// Burst initiator for a single-port array with 1-cycle registered reads.
// Ports: req_* command channel, wdata_* write stream, rdata_* read
// stream (with last), done pulse, arr_* array-side signals.
module array_burst_master
    import array_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2048,
    parameter  int LEN_W = 4,
    localparam int AW    = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [AW-1:0]    req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    input  logic [WIDTH-1:0] wdata,
    output logic             rdata_valid,
    input  logic             rdata_ready,
    output logic [WIDTH-1:0] rdata,
    output logic             rdata_last,
    output logic             done,
    output logic [AW-1:0]    arr_addr,
    output logic             arr_rd_o_wr,
    output logic [WIDTH-1:0] arr_i_data,
    input  logic [WIDTH-1:0] arr_o_data
);

    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] data;
    } rd_word_t;

    state_t           r_state;
    logic [AW-1:0]    r_addr;
    logic [AW-1:0]    r_hold;
    logic [LEN_W:0]   r_rem;
    logic             r_inflight;
    logic             r_infl_last;

    logic             w_wacc;
    logic             w_pop;
    logic             w_issue;
    logic             w_last;
    logic             w_full;
    logic             w_empty;
    logic [1:0]       w_cnt;
    logic [1:0]       w_credit;
    logic [AW-1:0]    w_addr_inc;
    logic [LEN_W:0]   w_len_ext;
    rd_word_t         w_push_word;
    rd_word_t         w_head;

    assign w_wacc = (r_state == WRITE) && wdata_valid;
    assign w_pop  = rdata_valid && rdata_ready;
    assign w_last = (r_rem == (LEN_W+1)'(1));

    // Words already buffered (after this cycle's pop) plus the one whose
    // array output lands next cycle must leave room for a new issue.
    assign w_cnt    = w_full ? 2'd2 : (w_empty ? 2'd0 : 2'd1);
    assign w_credit = w_cnt - 2'(w_pop) + 2'(r_inflight);
    assign w_issue  = (r_state == READ) && (w_credit < 2'd2);

    assign w_addr_inc = (r_addr == AW'(DEPTH - 1)) ? '0 : r_addr + 1'b1;
    assign w_len_ext  = (req_len == '0) ? {1'b1, {LEN_W{1'b0}}}
                                        : {1'b0, req_len};

    assign req_ready   = (r_state == IDLE);
    assign wdata_ready = (r_state == WRITE);
    assign arr_rd_o_wr = w_wacc;
    assign arr_i_data  = (r_state == WRITE) ? wdata : '0;
    // Outside an active burst the address parks on its last value.
    assign arr_addr    = (r_state == WRITE || r_state == READ) ? r_addr
                                                               : r_hold;
    assign done        = (w_wacc && w_last) || (r_state == DRAIN);

    assign w_push_word = '{last: r_infl_last, data: arr_o_data};

    array_rd_fifo #(
        .DW (WIDTH + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_data  (w_push_word),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign rdata_valid = !w_empty;
    assign rdata       = w_head.data;
    assign rdata_last  = w_head.last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_hold      <= '0;
            r_rem       <= '0;
            r_inflight  <= 1'b0;
            r_infl_last <= 1'b0;
        end else begin
            r_hold      <= arr_addr;
            r_inflight  <= w_issue;
            r_infl_last <= w_issue && w_last;
            unique case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_rem   <= w_len_ext;
                        r_state <= req_wr ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (w_wacc) begin
                        r_addr <= w_addr_inc;
                        r_rem  <= r_rem - 1'b1;
                        if (w_last) r_state <= IDLE;
                    end
                end
                READ: begin
                    if (w_issue) begin
                        r_addr <= w_addr_inc;
                        r_rem  <= r_rem - 1'b1;
                        if (w_last) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
